mem_access_sequencer: RTL and testbench



---
 rtl/mem_access_sequencer.sv | 139 +++++++++++++
 tb/tb_mem_access_sequencer.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_sequencer.sv
// mem_access_sequencer: runs one load or store from the single-cycle core
// against a multi-cycle data memory using a req/ack handshake. The core is
// stalled while an access is outstanding. A misaligned access, a conflicting
// read+write, or a memory timeout latches a sticky fault that halts the core.
module mem_access_sequencer #(
   parameter int TIMEOUT = 64          // legal range 1..255
) (
   input  logic        clk,
   input  logic        rst_b,
   input  logic        mem_read,
   input  logic        mem_write_en,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        stall,
   output logic [31:0] load_data,
   output logic        load_valid,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        mem_fault,
   output logic [1:0]  fault_code
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE, ERR} state_t;

   localparam logic [1:0] CODE_MISALIGNED = 2'd1;
   localparam logic [1:0] CODE_TIMEOUT    = 2'd2;
   localparam logic [1:0] CODE_CONFLICT   = 2'd3;

   // Last BUSY cycle index that may still complete; without an ack here we fault.
   localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

   state_t      state, state_nxt;
   logic [31:0] addr_q, wdata_q, load_data_q;
   logic        we_q;
   logic [1:0]  code_q;
   logic [7:0]  wait_cnt;

   logic access, conflict, misaligned, timed_out;

   assign access     = mem_read | mem_write_en;
   assign conflict   = mem_read & mem_write_en;
   assign misaligned = (addr[1:0] != 2'b00);
   assign timed_out  = (wait_cnt == LAST_WAIT);

   // Memory port and fault outputs come straight from the latched request.
   assign mem_we     = we_q;
   assign mem_addr   = addr_q;
   assign mem_wdata  = wdata_q;
   assign load_data  = load_data_q;
   assign fault_code = code_q;

   // State register.
   always_ff @(posedge clk or negedge rst_b) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      if (!rst_b) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state and combinational handshake/stall outputs.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves one
      // unassigned, which would otherwise infer a latch.
      state_nxt  = state;
      stall      = 1'b0;
      mem_req    = 1'b0;
      load_valid = 1'b0;
      mem_fault  = 1'b0;
      unique case (state)
         IDLE: begin
            if (access) begin
               stall = 1'b1;
               if (conflict || misaligned) state_nxt = ERR;
               else                        state_nxt = BUSY;
            end
         end
         BUSY: begin
            stall   = 1'b1;
            mem_req = 1'b1;
            if (mem_ack)        state_nxt = DONE;
            else if (timed_out) state_nxt = ERR;
         end
         DONE: begin
            // Inputs here belong to the retiring instruction and are ignored.
            load_valid = ~we_q;
            state_nxt  = IDLE;
         end
         ERR: begin
            stall     = 1'b1;
            mem_fault = 1'b1;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Request latches, wait counter, load data capture and sticky fault code.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         addr_q      <= '0;
         wdata_q     <= '0;
         we_q        <= 1'b0;
         load_data_q <= '0;
         code_q      <= 2'd0;
         wait_cnt    <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               wait_cnt <= '0;
               if (access) begin
                  if (conflict) begin
                     code_q <= CODE_CONFLICT;
                  end else if (misaligned) begin
                     code_q <= CODE_MISALIGNED;
                  end else begin
                     addr_q  <= addr;
                     wdata_q <= wdata;
                     we_q    <= mem_write_en;
                  end
               end
            end
            BUSY: begin
               if (mem_ack) begin
                  if (!we_q) load_data_q <= mem_rdata;
               end else if (timed_out) begin
                  code_q <= CODE_TIMEOUT;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Directed bench for mem_access_sequencer (TIMEOUT=4). Inputs change on the
// falling edge; outputs are sampled 1ns later, well clear of the rising edge.
module tb_mem_access_sequencer;

   logic        clk = 1'b0;
   logic        rst_b = 1'b0;
   logic        mem_read = 1'b0;
   logic        mem_write_en = 1'b0;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;
   logic        stall;
   logic [31:0] load_data;
   logic        load_valid;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic        mem_fault;
   logic [1:0]  fault_code;

   int vectors = 0;
   int miscompares = 0;

   mem_access_sequencer #(.TIMEOUT(4)) dut (
      .clk(clk), .rst_b(rst_b),
      .mem_read(mem_read), .mem_write_en(mem_write_en),
      .addr(addr), .wdata(wdata),
      .stall(stall), .load_data(load_data), .load_valid(load_valid),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .mem_fault(mem_fault), .fault_code(fault_code)
   );

   always #5 clk = ~clk;

   // Advance to the next falling edge (one full clock later).
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      mem_read = 1'b0; mem_write_en = 1'b0; addr = '0; wdata = '0;
      mem_ack = 1'b0; mem_rdata = '0;
   endtask

   task automatic apply_reset();
      idle_inputs();
      @(negedge clk);
      rst_b = 1'b0;
      tick();
      rst_b = 1'b1;
   endtask

   task automatic test_reset();
      apply_reset();
      #1;
      vectors++;
      if ({stall, mem_req, mem_we, load_valid, mem_fault, fault_code} !== 7'b0) begin
         miscompares++;
         $display("FAIL reset_ctrl: got stall=%b req=%b we=%b lv=%b fault=%b code=%0d want all 0",
                  stall, mem_req, mem_we, load_valid, mem_fault, fault_code);
      end
      vectors++;
      if ({load_data, mem_addr, mem_wdata} !== 96'b0) begin
         miscompares++;
         $display("FAIL reset_data: got ld=%h addr=%h wd=%h want 0", load_data, mem_addr, mem_wdata);
      end
      @(negedge clk);
   endtask

   // Load to 0x10, ack in the 3rd BUSY cycle -> 4 stall cycles.
   task automatic test_load_wait();
      int stalls;
      mem_read = 1'b1; addr = 32'h10; wdata = 32'hAAAA5555;
      #1;
      stalls = int'(stall);
      vectors++;
      if (mem_req !== 1'b0) begin
         miscompares++; $display("FAIL load_detect_req: got %b want 0", mem_req);
      end
      tick();
      mem_read = 1'b0; addr = '0;
      for (int i = 1; i <= 3; i++) begin
         mem_ack = (i == 3); mem_rdata = (i == 3) ? 32'hDEADBEEF : 32'h0;
         #1;
         stalls += int'(stall);
         vectors++;
         if ({mem_req, mem_we, load_valid} !== 3'b100 || mem_addr !== 32'h10) begin
            miscompares++;
            $display("FAIL load_busy%0d: got req=%b we=%b lv=%b addr=%h want 1 0 0 00000010",
                     i, mem_req, mem_we, load_valid, mem_addr);
         end
         tick();
      end
      mem_ack = 1'b0; mem_rdata = '0;
      #1;
      stalls += int'(stall);
      vectors++;
      if ({load_valid, mem_req} !== 2'b10 || load_data !== 32'hDEADBEEF) begin
         miscompares++;
         $display("FAIL load_done: got lv=%b req=%b ld=%h want 1 0 deadbeef", load_valid, mem_req, load_data);
      end
      tick();
      #1;
      vectors++;
      if (stalls !== 4) begin
         miscompares++; $display("FAIL load_stall_count: got %0d want 4", stalls);
      end
      vectors++;
      if (load_valid !== 1'b0 || load_data !== 32'hDEADBEEF) begin
         miscompares++; $display("FAIL load_hold: got lv=%b ld=%h want 0 deadbeef", load_valid, load_data);
      end
      @(negedge clk);
   endtask

   // Store to 0x20, ack in the first BUSY cycle -> 2 stall cycles.
   task automatic test_store();
      int stalls;
      mem_write_en = 1'b1; addr = 32'h20; wdata = 32'h12345678;
      #1;
      stalls = int'(stall);
      tick();
      idle_inputs();
      mem_ack = 1'b1; mem_rdata = 32'h0BADF00D;
      #1;
      stalls += int'(stall);
      vectors++;
      if ({mem_req, mem_we} !== 2'b11 || mem_addr !== 32'h20 || mem_wdata !== 32'h12345678) begin
         miscompares++;
         $display("FAIL store_busy: got req=%b we=%b addr=%h wd=%h want 1 1 00000020 12345678",
                  mem_req, mem_we, mem_addr, mem_wdata);
      end
      tick();
      mem_ack = 1'b0; mem_rdata = '0;
      #1;
      stalls += int'(stall);
      vectors++;
      if (load_valid !== 1'b0 || load_data !== 32'hDEADBEEF) begin
         miscompares++; $display("FAIL store_done: got lv=%b ld=%h want 0 deadbeef", load_valid, load_data);
      end
      vectors++;
      if (stalls !== 2) begin
         miscompares++; $display("FAIL store_stall_count: got %0d want 2", stalls);
      end
      tick();
   endtask

   // Load completes; a store presented during DONE is ignored there and
   // accepted in the very next IDLE cycle.
   task automatic test_back_to_back();
      mem_read = 1'b1; addr = 32'h40;
      tick();
      mem_read = 1'b0; addr = '0; mem_ack = 1'b1; mem_rdata = 32'h11112222;
      tick();
      mem_ack = 1'b0; mem_rdata = '0;
      mem_write_en = 1'b1; addr = 32'h44; wdata = 32'h55;
      #1;
      vectors++;
      if ({stall, load_valid} !== 2'b01 || load_data !== 32'h11112222) begin
         miscompares++;
         $display("FAIL b2b_done: got stall=%b lv=%b ld=%h want 0 1 11112222", stall, load_valid, load_data);
      end
      tick();
      #1;
      vectors++;
      if ({stall, mem_req, load_valid} !== 3'b100) begin
         miscompares++;
         $display("FAIL b2b_detect: got stall=%b req=%b lv=%b want 1 0 0", stall, mem_req, load_valid);
      end
      tick();
      idle_inputs(); mem_ack = 1'b1;
      #1;
      vectors++;
      if ({mem_req, mem_we} !== 2'b11 || mem_addr !== 32'h44 || mem_wdata !== 32'h55) begin
         miscompares++;
         $display("FAIL b2b_store: got req=%b we=%b addr=%h wd=%h want 1 1 00000044 00000055",
                  mem_req, mem_we, mem_addr, mem_wdata);
      end
      tick();
      mem_ack = 1'b0;
      tick();
   endtask

   // No ack for 4 BUSY cycles -> timeout fault; then ack on the 4th cycle wins.
   task automatic test_timeout();
      int req_cycles;
      apply_reset();
      mem_read = 1'b1; addr = 32'h80;
      tick();
      mem_read = 1'b0; addr = '0;
      req_cycles = 0;
      for (int i = 0; i < 8; i++) begin
         #1;
         req_cycles += int'(mem_req);
         tick();
         mem_ack = (i >= 5);   // late ack once in ERR must not matter
      end
      #1;
      vectors++;
      if (req_cycles !== 4) begin
         miscompares++; $display("FAIL timeout_req_cycles: got %0d want 4", req_cycles);
      end
      vectors++;
      if ({mem_req, stall, mem_fault} !== 3'b011 || fault_code !== 2'd2) begin
         miscompares++;
         $display("FAIL timeout_err: got req=%b stall=%b fault=%b code=%0d want 0 1 1 2",
                  mem_req, stall, mem_fault, fault_code);
      end

      apply_reset();
      mem_read = 1'b1; addr = 32'h84;
      tick();
      mem_read = 1'b0; addr = '0;
      for (int i = 1; i <= 4; i++) begin
         mem_ack = (i == 4); mem_rdata = (i == 4) ? 32'hCAFEF00D : 32'h0;
         tick();
      end
      mem_ack = 1'b0; mem_rdata = '0;
      #1;
      vectors++;
      if ({load_valid, mem_fault} !== 2'b10 || fault_code !== 2'd0 || load_data !== 32'hCAFEF00D) begin
         miscompares++;
         $display("FAIL timeout_ack_wins: got lv=%b fault=%b code=%0d ld=%h want 1 0 0 cafef00d",
                  load_valid, mem_fault, fault_code, load_data);
      end
      tick();
   endtask

   task automatic test_misaligned();
      int req_seen;
      apply_reset();
      mem_read = 1'b1; addr = 32'h6;
      #1;
      req_seen = int'(mem_req);
      vectors++;
      if (stall !== 1'b1) begin
         miscompares++; $display("FAIL misalign_detect_stall: got %b want 1", stall);
      end
      tick();
      idle_inputs();
      for (int i = 0; i < 5; i++) begin
         #1;
         req_seen += int'(mem_req);
         tick();
      end
      #1;
      vectors++;
      if (req_seen !== 0 || {stall, mem_fault} !== 2'b11 || fault_code !== 2'd1) begin
         miscompares++;
         $display("FAIL misalign_err: got req_cycles=%0d stall=%b fault=%b code=%0d want 0 1 1 1",
                  req_seen, stall, mem_fault, fault_code);
      end
      @(negedge clk);
   endtask

   task automatic test_conflict();
      apply_reset();
      mem_read = 1'b1; mem_write_en = 1'b1; addr = 32'h3;
      tick();
      idle_inputs();
      tick();
      #1;
      vectors++;
      if ({mem_req, mem_fault} !== 2'b01 || fault_code !== 2'd3) begin
         miscompares++;
         $display("FAIL conflict_err: got req=%b fault=%b code=%0d want 0 1 3", mem_req, mem_fault, fault_code);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_access();
      apply_reset();
      mem_read = 1'b1; addr = 32'h10;
      tick();
      idle_inputs();
      #2;
      rst_b = 1'b0;
      #1;
      vectors++;
      if ({mem_req, stall, mem_fault} !== 3'b000 || mem_addr !== 32'h0) begin
         miscompares++;
         $display("FAIL async_reset: got req=%b stall=%b fault=%b addr=%h want 0 0 0 00000000",
                  mem_req, stall, mem_fault, mem_addr);
      end
      @(negedge clk);
      rst_b = 1'b1;
      mem_ack = 1'b1; mem_rdata = 32'h77778888;
      tick();
      tick();
      #1;
      vectors++;
      if ({mem_req, stall, load_valid, mem_fault} !== 4'b0 || load_data !== 32'h0) begin
         miscompares++;
         $display("FAIL late_ack_ignored: got req=%b stall=%b lv=%b fault=%b ld=%h want 0 0 0 0 0",
                  mem_req, stall, load_valid, mem_fault, load_data);
      end
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_load_wait();
      test_store();
      test_back_to_back();
      test_timeout();
      test_misaligned();
      test_conflict();
      test_reset_mid_access();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
